// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and entry type for the fetch stage
package fetch_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_0000;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam int          FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Redirect target: address after the branch plus a word offset, wrapping mod 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] br_pc,
                                                  input logic [31:0] immed);
        return br_pc + PC_STEP + {immed[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small FIFO of {pc, instr} entries with synchronous flush
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    output logic [63:0] head_data,
    output logic        empty,
    output logic [1:0]  count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [63:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == 2'd0);
    assign full      = (count == 2'(FIFO_DEPTH));
    assign head_data = mem[rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage and pointers; flush drops all entries but leaves stale words in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with 2-entry return buffer and branch redirect; optional FETCH_PERF_CNT_EN counters
module fetch_stage
    import fetch_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] IMEM_addr,
    output logic        IMEM_rd_en,
    input  logic [31:0] IMEM_data,
    output logic [31:0] Instr,
    output logic [31:0] Instr_PC,
    output logic        Instr_valid,
    input  logic        Dec_ready,
    input  logic        PC_sel,
    input  logic [31:0] Br_PC,
    input  logic [31:0] Immed
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_cnt,
    output logic [15:0] Flush_cnt
`endif
);

    fetch_state_t state;
    fetch_state_t next_state;

    logic [31:0]  pc;
    logic         inflight;
    logic [31:0]  inflight_pc;

    logic         rd_en;
    logic         push;
    logic         pop;
    logic         flush;
    logic [2:0]   occ_after_pop;

    logic [63:0]  head_data;
    fetch_entry_t head;
    logic         fifo_empty;
    logic [1:0]   fifo_count;

    assign head        = fetch_entry_t'(head_data);
    assign Instr       = head.instr;
    assign Instr_PC    = head.pc;
    assign Instr_valid = !fifo_empty;
    assign IMEM_addr   = pc;
    assign IMEM_rd_en  = rd_en;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and per-cycle controls; a redirect overrides pop, push and fetch.
    // The fetch budget counts the slot freed by this cycle's pop so decode can drain one word per cycle.
    always_comb begin
        next_state    = state;
        rd_en         = 1'b0;
        flush         = PC_sel;
        pop           = Instr_valid && Dec_ready && !PC_sel;
        push          = inflight && !PC_sel;
        occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        case (state)
            IDLE: begin
                next_state = RUN;
            end
            RUN: begin
                if (PC_sel) begin
                    next_state = FLUSH;
                end
                rd_en = !PC_sel && (occ_after_pop < 3'(FIFO_DEPTH));
            end
            FLUSH: begin
                next_state = PC_sel ? FLUSH : RUN;
                rd_en      = !PC_sel && (occ_after_pop < 3'(FIFO_DEPTH));
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Program counter and the single outstanding request; a redirect drops the response in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc          <= PC_RESET;
            inflight    <= 1'b0;
            inflight_pc <= PC_RESET;
        end else if (PC_sel) begin
            pc       <= branch_target(Br_PC, Immed);
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                pc          <= pc + PC_STEP;
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .flush     (flush),
        .push      (push),
        .push_data ({inflight_pc, IMEM_data}),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    // Delivered-instruction and redirect counters, both free-running and wrapping.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Fetch_cnt <= 32'd0;
            Flush_cnt <= 16'd0;
        end else begin
            if (pop) begin
                Fetch_cnt <= Fetch_cnt + 32'd1;
            end
            if (PC_sel) begin
                Flush_cnt <= Flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] IMEM_addr;
    logic        IMEM_rd_en;
    logic [31:0] IMEM_data;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_valid;
    logic        Dec_ready;
    logic        PC_sel;
    logic [31:0] Br_PC;
    logic [31:0] Immed;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Fetch_cnt;
    logic [15:0] Flush_cnt;
`endif

    int          tests = 0;
    int          fails = 0;
    int          fetch_total = 0;
    int          fetch_base;
    logic [31:0] exp_q [$];

    fetch_stage dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .IMEM_addr   (IMEM_addr),
        .IMEM_rd_en  (IMEM_rd_en),
        .IMEM_data   (IMEM_data),
        .Instr       (Instr),
        .Instr_PC    (Instr_PC),
        .Instr_valid (Instr_valid),
        .Dec_ready   (Dec_ready),
        .PC_sel      (PC_sel),
        .Br_PC       (Br_PC),
        .Immed       (Immed)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Fetch_cnt   (Fetch_cnt),
        .Flush_cnt   (Flush_cnt)
`endif
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Instruction memory: answers a request one cycle later with an address-tagged word.
    initial begin
        logic        r;
        logic [31:0] a;
        IMEM_data = 32'hDEAD_BEEF;
        forever begin
            @(negedge Clk);
            r = IMEM_rd_en;
            a = IMEM_addr;
            @(posedge Clk);
            #1;
            IMEM_data = r ? tag(a) : 32'hDEAD_BEEF;
        end
    end

    // Monitor: counts fetches and checks every delivered instruction against the queue.
    initial begin
        logic [31:0] e_pc;
        forever begin
            @(negedge Clk);
            if (IMEM_rd_en) fetch_total++;
            if (!Reset && Instr_valid && Dec_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_delivery: got pc %h, required no delivery", Instr_PC);
                end else begin
                    e_pc = exp_q.pop_front();
                    check("deliver_pc", Instr_PC, e_pc);
                    check("deliver_instr", Instr, tag(e_pc));
                end
            end
        end
    end

    initial begin
        Reset     = 1'b1;
        Dec_ready = 1'b1;
        PC_sel    = 1'b0;
        Br_PC     = 32'h0;
        Immed     = 32'h0;
        tick;
        tick;

        // Reset values
        check("rst_valid", {31'b0, Instr_valid}, 32'h0);
        check("rst_rd_en", {31'b0, IMEM_rd_en}, 32'h0);
        check("rst_addr", IMEM_addr, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_instr_pc", Instr_PC, 32'h0);

        // Streaming from reset: 0x0, 0x4, 0x8 on consecutive cycles from the third edge
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        Reset = 1'b0;
        #1;
        check("idle_no_fetch", {31'b0, IMEM_rd_en}, 32'h0);
        tick;
        check("e1_rd_en", {31'b0, IMEM_rd_en}, 32'h1);
        check("e1_addr", IMEM_addr, 32'h0);
        tick;
        check("e2_valid", {31'b0, Instr_valid}, 32'h0);
        check("e2_addr", IMEM_addr, 32'h4);
        tick;
        check("e3_valid", {31'b0, Instr_valid}, 32'h1);
        tick;
        check("e4_valid", {31'b0, Instr_valid}, 32'h1);
        tick;
        check("e5_valid", {31'b0, Instr_valid}, 32'h1);
        tick;
        check("stream_drained", exp_q.size(), 32'd0);

        // Redirect with an in-flight word: target 0x10 + 4 - 8 = 0x0C
        Dec_ready = 1'b0;
        PC_sel    = 1'b1;
        Br_PC     = 32'h0000_0010;
        Immed     = 32'hFFFF_FFFE;
        #1;
        check("redir_no_fetch", {31'b0, IMEM_rd_en}, 32'h0);
        tick;
        PC_sel = 1'b0;
        #1;
        check("redir_addr", IMEM_addr, 32'h0000_000C);
        check("redir_rd_en", {31'b0, IMEM_rd_en}, 32'h1);
        check("redir_flushed", {31'b0, Instr_valid}, 32'h0);
        tick;
        check("redir_p1_valid", {31'b0, Instr_valid}, 32'h0);
        tick;
        check("redir_p2_valid", {31'b0, Instr_valid}, 32'h1);
        check("redir_p2_pc", Instr_PC, 32'h0000_000C);
        exp_q.push_back(32'h0000_000C);
        Dec_ready = 1'b1;
        tick;
        Dec_ready = 1'b0;

        // Redirect wrapping past 2^32: 0xFFFFFFF8 + 4 + 12 = 0x8
        PC_sel = 1'b1;
        Br_PC  = 32'hFFFF_FFF8;
        Immed  = 32'h0000_0003;
        tick;
        PC_sel = 1'b0;
        #1;
        check("wrap_addr", IMEM_addr, 32'h0000_0008);
        check("wrap_rd_en", {31'b0, IMEM_rd_en}, 32'h1);
        tick;
        tick;
        check("wrap_valid", {31'b0, Instr_valid}, 32'h1);
        check("wrap_pc", Instr_PC, 32'h0000_0008);
        exp_q.push_back(32'h0000_0008);
        Dec_ready = 1'b1;
        tick;
        Dec_ready = 1'b0;
        check("redir_drained", exp_q.size(), 32'd0);

        // Decode stalled for 5 cycles after reset: two fetches, head held stable
        Reset = 1'b1;
        exp_q.delete();
        tick;
        tick;
        Reset      = 1'b0;
        fetch_base = fetch_total;
        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("stall_valid", {31'b0, Instr_valid}, 32'h1);
            check("stall_pc_stable", Instr_PC, 32'h0);
        end
        check("stall_fetch_count", fetch_total - fetch_base, 32'd2);
        check("stall_rd_en_low", {31'b0, IMEM_rd_en}, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        Dec_ready = 1'b1;
        tick;
        tick;
        Dec_ready = 1'b0;
        check("stall_drained", exp_q.size(), 32'd0);
        tick;

        // Asynchronous reset mid-cycle with two buffered entries
        #2;
        Reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_valid", {31'b0, Instr_valid}, 32'h0);
        check("async_rd_en", {31'b0, IMEM_rd_en}, 32'h0);
        check("async_instr_pc", Instr_PC, 32'h0);
        check("async_instr", Instr, 32'h0);
        tick;
        Reset = 1'b0;
        tick;
        check("restart_addr", IMEM_addr, 32'h0);
        check("restart_rd_en", {31'b0, IMEM_rd_en}, 32'h1);

        // Ten deliveries, then three back-to-back redirects
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        Dec_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick;
        Dec_ready = 1'b0;
        check("ten_drained", exp_q.size(), 32'd0);
        PC_sel = 1'b1;
        Br_PC  = 32'h0000_0100;
        Immed  = 32'h0;
        tick;
        check("double_redir_no_fetch", {31'b0, IMEM_rd_en}, 32'h0);
        tick;
        tick;
        PC_sel = 1'b0;
        #1;
        check("triple_redir_addr", IMEM_addr, 32'h0000_0104);
        check("triple_redir_rd_en", {31'b0, IMEM_rd_en}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", Fetch_cnt, 32'd10);
        check("flush_cnt", {16'b0, Flush_cnt}, 32'd3);
`endif
        tick;
        tick;
        tick;
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
